vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 76 +++++++
 tb/tb_vga_sync_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: H/V counters with combinational sync, video-window and frame-start decode.
// Define VGA_CLK_DIV_EN to run from a 4x clock through a 2-bit prescaler; otherwise clk is the pixel clock.
module vga_sync_gen #(
   parameter int H_TOTAL      = 800,
   parameter int H_SYNC_W     = 96,
   parameter int H_DISP_FIRST = 144,
   parameter int H_DISP_LAST  = 783,
   parameter int V_TOTAL      = 525,
   parameter int V_SYNC_W     = 2,
   parameter int V_DISP_FIRST = 35,
   parameter int V_DISP_LAST  = 514
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] H_Counter_Value,
   output logic [15:0] V_Counter_Value,
   output logic        Hsync,
   output logic        Vsync,
   output logic        Video_On,
   output logic        Pixel_Tick,
   output logic        Frame_Start
);

   localparam logic [15:0] H_MAX   = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_MAX   = 16'(V_TOTAL - 1);
   localparam logic [15:0] H_SYNC  = 16'(H_SYNC_W);
   localparam logic [15:0] V_SYNC  = 16'(V_SYNC_W);
   localparam logic [15:0] H_FIRST = 16'(H_DISP_FIRST);
   localparam logic [15:0] H_LAST  = 16'(H_DISP_LAST);
   localparam logic [15:0] V_FIRST = 16'(V_DISP_FIRST);
   localparam logic [15:0] V_LAST  = 16'(V_DISP_LAST);

   logic [15:0] h_cnt;
   logic [15:0] v_cnt;
   logic        pixel_tick;

`ifdef VGA_CLK_DIV_EN
   logic [1:0] prescale;

   always_ff @(posedge clk) begin
      if (reset) prescale <= 2'd0;
      else       prescale <= prescale + 2'd1;
   end

   // Tick on the last phase so the first advance lands on the 4th clock after release.
   assign pixel_tick = (prescale == 2'd3);
`else
   assign pixel_tick = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= 16'd0;
         v_cnt <= 16'd0;
      end else if (pixel_tick) begin
         if (h_cnt == H_MAX) begin
            h_cnt <= 16'd0;
            if (v_cnt == V_MAX) v_cnt <= 16'd0;
            else                v_cnt <= v_cnt + 16'd1;
         end else begin
            h_cnt <= h_cnt + 16'd1;
         end
      end
   end

   assign H_Counter_Value = h_cnt;
   assign V_Counter_Value = v_cnt;
   assign Pixel_Tick      = pixel_tick;
   assign Hsync           = !(h_cnt < H_SYNC);
   assign Vsync           = !(v_cnt < V_SYNC);
   assign Video_On        = (h_cnt >= H_FIRST) && (h_cnt <= H_LAST) &&
                            (v_cnt >= V_FIRST) && (v_cnt <= V_LAST);
   // Gated by reset so the strobe stays quiet while the counters are being held at origin.
   assign Frame_Start     = pixel_tick && !reset && (h_cnt == 16'd0) && (v_cnt == 16'd0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance plus a shrunken-timing instance, checked against an arithmetic model.
module tb_vga_sync_gen;

   localparam int S_HT = 40, S_HS = 6, S_HF = 10, S_HL = 35;
   localparam int S_VT = 20, S_VS = 2, S_VF = 3,  S_VL = 17;
`ifdef VGA_CLK_DIV_EN
   localparam int DIV = 4;
`else
   localparam int DIV = 1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic [15:0] a_h, a_v, b_h, b_v;
   logic a_hs, a_vs, a_von, a_tick, a_fs;
   logic b_hs, b_vs, b_von, b_tick, b_fs;

   int n_edges = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vga_sync_gen u_def (
      .clk(clk), .reset(reset),
      .H_Counter_Value(a_h), .V_Counter_Value(a_v),
      .Hsync(a_hs), .Vsync(a_vs), .Video_On(a_von),
      .Pixel_Tick(a_tick), .Frame_Start(a_fs)
   );

   vga_sync_gen #(
      .H_TOTAL(S_HT), .H_SYNC_W(S_HS), .H_DISP_FIRST(S_HF), .H_DISP_LAST(S_HL),
      .V_TOTAL(S_VT), .V_SYNC_W(S_VS), .V_DISP_FIRST(S_VF), .V_DISP_LAST(S_VL)
   ) u_small (
      .clk(clk), .reset(reset),
      .H_Counter_Value(b_h), .V_Counter_Value(b_v),
      .Hsync(b_hs), .Vsync(b_vs), .Video_On(b_von),
      .Pixel_Tick(b_tick), .Frame_Start(b_fs)
   );

   // Clocks elapsed since the last edge that sampled reset high.
   always @(posedge clk) begin
      if (reset) n_edges <= 0;
      else       n_edges <= n_edges + 1;
   end

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (clk %0d since reset)", tag, act, exp, n_edges);
      end
   endtask

   // Pixel position is simply elapsed ticks folded by line and frame length.
   function automatic void model(input int n, input int ht, input int hsw, input int hf, input int hl,
                                 input int vt, input int vsw, input int vf, input int vl, input bit rst,
                                 output int h, output int v, output int hs, output int vs,
                                 output int von, output int tick, output int fs);
      int t;
      t    = n / DIV;
      tick = ((n % DIV) == DIV - 1) ? 1 : 0;
      h    = t % ht;
      v    = (t / ht) % vt;
      hs   = (h < hsw) ? 0 : 1;
      vs   = (v < vsw) ? 0 : 1;
      von  = (h >= hf && h <= hl && v >= vf && v <= vl) ? 1 : 0;
      fs   = (tick == 1 && h == 0 && v == 0 && !rst) ? 1 : 0;
   endfunction

   task automatic check_all();
      int h, v, hs, vs, von, tick, fs;
      model(n_edges, 800, 96, 144, 783, 525, 2, 35, 514, reset, h, v, hs, vs, von, tick, fs);
      chk("def_h", int'(a_h), h);
      chk("def_v", int'(a_v), v);
      chk("def_hsync", int'(a_hs), hs);
      chk("def_vsync", int'(a_vs), vs);
      chk("def_video_on", int'(a_von), von);
      chk("def_tick", int'(a_tick), tick);
      chk("def_frame_start", int'(a_fs), fs);
      model(n_edges, S_HT, S_HS, S_HF, S_HL, S_VT, S_VS, S_VF, S_VL, reset, h, v, hs, vs, von, tick, fs);
      chk("small_h", int'(b_h), h);
      chk("small_v", int'(b_v), v);
      chk("small_hsync", int'(b_hs), hs);
      chk("small_vsync", int'(b_vs), vs);
      chk("small_video_on", int'(b_von), von);
      chk("small_tick", int'(b_tick), tick);
      chk("small_frame_start", int'(b_fs), fs);
   endtask

   initial begin
      int ticks, hs_low, vs_low, von_cnt, fs_def, fs_small;
      ticks = 0; hs_low = 0; vs_low = 0; von_cnt = 0; fs_def = 0; fs_small = 0;

      // Reset held for three clocks: everything parked at origin.
      repeat (3) begin
         @(negedge clk);
         reset = 1'b1;
         #1;
         chk("rst_h", int'(a_h), 0);
         chk("rst_v", int'(a_v), 0);
         chk("rst_hsync", int'(a_hs), 0);
         chk("rst_vsync", int'(a_vs), 0);
         chk("rst_video_on", int'(a_von), 0);
         chk("rst_frame_start", int'(a_fs), 0);
         check_all();
      end

      // Three small frames / three default lines with no interruption.
      for (int i = 0; i < 2400 * DIV; i++) begin
         @(negedge clk);
         reset = 1'b0;
         #1;
         check_all();
         if (a_tick) ticks++;
         if (a_tick && !a_hs) hs_low++;
         if (b_tick && !b_vs) vs_low++;
         if (b_tick && b_von) von_cnt++;
         if (a_fs) fs_def++;
         if (b_fs) fs_small++;
      end
      chk("win_ticks", ticks, 2400);
      chk("win_def_hsync_low", hs_low, 3 * 96);
      chk("win_small_vsync_low", vs_low, 3 * S_VS * S_HT);
      chk("win_small_video_on", von_cnt, 3 * (S_HL - S_HF + 1) * (S_VL - S_VF + 1));
      chk("win_def_frame_start", fs_def, 1);
      chk("win_small_frame_start", fs_small, 3);

      // Random single-cycle resets landing anywhere mid-frame.
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) == 0);
         #1;
         check_all();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
